// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, radix constants and adder FSM states
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_RADIX = 10;
  localparam int BCD_CORR  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD add with decimal correction
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  logic [4:0] s;
  logic [4:0] s_corr;

  // Raw sum is 0..31; the correction wraps mod 16, so non-BCD inputs stay deterministic.
  always_comb begin
    s      = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s_corr = s + 5'(BCD_CORR);
    digit  = s[3:0];
    cout   = 1'b0;
    if (s >= 5'(BCD_RADIX)) begin
      digit = s_corr[3:0];
      cout  = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial BCD adder, LSD first; BCD_SERIAL_ADDER_CHECK_EN enables ERR
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                C_IN,
  output logic                BUSY,
  output logic                DONE,
  output logic [4*DIGITS-1:0] SUM,
  output logic                COUT,
  output logic                ERR
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W-1:0]     sum_r;
  logic             carry;
  logic             cout_r;
  logic             accept;
  logic             last;
  bcd_digit_t       dig;
  logic             dig_cout;

  // Operands shift right each ADD cycle, so the current digit is always the bottom nibble.
  bcd_digit_add u_digit (
    .a     (a_sh[3:0]),
    .b     (b_sh[3:0]),
    .cin   (carry),
    .digit (dig),
    .cout  (dig_cout)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    last      = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        BUSY = 1'b1;
        if (last) state_nxt = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      carry  <= C_IN;
      sum_r  <= '0;
      cout_r <= 1'b0;
      idx    <= '0;
    end else if (BUSY) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      carry <= dig_cout;
      // New digit enters at the top; after DIGITS shifts digit0 lands in SUM[3:0].
      sum_r <= W'({dig, sum_r} >> 4);
      idx   <= last ? '0 : idx + 1'b1;
      if (last) cout_r <= dig_cout;
    end
  end

`ifdef BCD_SERIAL_ADDER_CHECK_EN
  logic err_acc;
  logic err_r;
  logic digit_bad;

  assign digit_bad = (a_sh[3:0] > 4'(BCD_RADIX - 1)) || (b_sh[3:0] > 4'(BCD_RADIX - 1));

  // Accumulate silently during ADD and publish together with COUT at the last digit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_acc <= 1'b0;
      err_r   <= 1'b0;
    end else if (accept) begin
      err_acc <= 1'b0;
      err_r   <= 1'b0;
    end else if (BUSY) begin
      err_acc <= err_acc | digit_bad;
      if (last) err_r <= err_acc | digit_bad;
    end
  end

  assign ERR = err_r;
`else
  assign ERR = 1'b0;
`endif

  assign SUM  = sum_r;
  assign COUT = cout_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - randomized bench for bcd_serial_adder against a digit-rule model
module tb_bcd_serial_adder;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int checks = 0;
  int errors = 0;

  // Expected view: phase 0 = idle, 1..D = busy cycles, D+1 = done cycle.
  int           phase    = 0;
  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;
  logic         exp_err  = 1'b0;
  logic [W-1:0] pend_sum;
  logic         pend_cout;
  logic         pend_err;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .CLK   (clk),
    .RESET (rst),
    .START (start),
    .A     (a),
    .B     (b),
    .C_IN  (c_in),
    .BUSY  (busy),
    .DONE  (done),
    .SUM   (sum),
    .COUT  (cout),
    .ERR   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                output logic [W-1:0] s, output logic co, output logic er);
    int c;
    c  = int'(ci);
    s  = '0;
    er = 1'b0;
    for (int i = 0; i < D; i++) begin
      int da;
      int db;
      int t;
      da = int'((x >> (4 * i)) & 16'hF);
      db = int'((y >> (4 * i)) & 16'hF);
      t  = da + db + c;
      if (da > 9 || db > 9) er = 1'b1;
      if (t >= 10) begin
        s = s | (W'((t + 6) % 16) << (4 * i));
        c = 1;
      end else begin
        s = s | (W'(t) << (4 * i));
        c = 0;
      end
    end
    co = (c != 0);
`ifndef BCD_SERIAL_ADDER_CHECK_EN
    er = 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", W'(busy), W'(phase >= 1 && phase <= D));
      chk("done", W'(done), W'(phase == D + 1));
      if (phase == 0 || phase == D + 1) begin
        chk("sum", sum, exp_sum);
        chk("cout", W'(cout), W'(exp_cout));
        chk("err", W'(err), W'(exp_err));
      end else begin
        chk("cout_busy", W'(cout), '0);
        chk("err_busy", W'(err), '0);
      end
    end
  end

  task automatic tick();
    bit           st;
    logic [W-1:0] la;
    logic [W-1:0] lb;
    logic         lc;
    st = start;
    la = a;
    lb = b;
    lc = c_in;
    @(posedge clk);
    #1;
    if (phase == 0) begin
      if (st) begin
        phase = 1;
        model(la, lb, lc, pend_sum, pend_cout, pend_err);
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_err  = 1'b0;
      end
    end else if (phase == D + 1) begin
      phase = 0;
    end else begin
      phase++;
    end
    if (phase == D + 1) begin
      exp_sum  = pend_sum;
      exp_cout = pend_cout;
      exp_err  = pend_err;
    end
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input bit use_lit, input logic [W-1:0] lsum, input logic lcout,
                       input logic lerr, input bit junk);
    int n;
    a     = x;
    b     = y;
    c_in  = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    c_in  = 1'($urandom);
    n     = 0;
    while (phase != D + 1 && n < 3 * D) begin
      if (junk && phase == 2) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    chk("latency", W'(n), W'(D));
    if (use_lit) begin
      chk("lit_sum", sum, lsum);
      chk("lit_cout", W'(cout), W'(lcout));
      chk("lit_err", W'(err), W'(lerr));
    end
    tick();
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) v = v | (W'($urandom_range(0, 9)) << (4 * i));
    return v;
  endfunction

  localparam logic ERR_ON =
`ifdef BCD_SERIAL_ADDER_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", W'(cout), '0);
    chk("rst_err", W'(err), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    do_op(16'h1234, 16'h5678, 1'b0, 1, 16'h6912, 1'b0, 1'b0, 0);
    do_op(16'h9999, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h0000, 16'h0000, 1'b1, 1, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h9999, 16'h9999, 1'b1, 1, 16'h9999, 1'b1, 1'b0, 0);
    do_op(16'h4321, 16'h1111, 1'b0, 1, 16'h5432, 1'b0, 1'b0, 1);

    // Reset during the second ADD cycle.
    a     = 16'h1234;
    b     = 16'h8765;
    c_in  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_sum", sum, '0);
    chk("abort_cout", W'(cout), '0);
    phase    = 0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_err  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    do_op(16'h0005, 16'h0005, 1'b0, 1, 16'h0010, 1'b0, 1'b0, 0);

    do_op(16'h000A, 16'h0000, 1'b0, 1, 16'h0010, 1'b0, ERR_ON, 0);
    do_op(16'h0123, 16'h0456, 1'b0, 1, 16'h0579, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      if (k % 5 == 4) begin
        x = W'($urandom);
        y = W'($urandom);
      end else begin
        x = rand_bcd();
        y = rand_bcd();
      end
      do_op(x, y, 1'($urandom), 0, '0, 1'b0, 1'b0, (k % 3) == 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
